// File: rtl/fifo_pkg.sv
// Shared sizing helpers and pointer arithmetic for param_sync_fifo.
package fifo_pkg;

    typedef logic [31:0] word_t;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Wrap by compare so non-power-of-two depths use every entry.
    function automatic word_t ptr_inc(input word_t ptr, input word_t depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bus for param_sync_fifo; error flags exist only with FIFO_ERR_FLAGS_EN.
interface param_sync_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CNT_W = fifo_pkg::cnt_w(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic [CNT_W-1:0] afull_thresh;
    logic [CNT_W-1:0] aempty_thresh;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    modport master (
        output wr_en, wr_data, rd_en, afull_thresh, aempty_thresh,
        input  rd_data, count, empty, full, almost_full, almost_empty
`ifdef FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  wr_en, wr_data, rd_en, afull_thresh, aempty_thresh,
        output rd_data, count, empty, full, almost_full, almost_empty
`ifdef FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );

endinterface

// File: rtl/fifo_mem_dp.sv
// FIFO storage: one synchronous write port, one read port that is either
// combinational (FWFT) or registered with enable.
module fifo_mem_dp #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata = mem[raddr];
        // Read enable and reset are meaningless for a combinational read port.
        logic unused_rd;
        assign unused_rd = ^{re, rst_n};
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO of any depth >= 2 with occupancy count, programmable
// almost flags and selectable read mode. FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned FWFT  = 0
) (
    input logic              clk,
    input logic              rst_n,
    param_sync_fifo_if.slave bus
);

    localparam int unsigned CNT_W  = cnt_w(DEPTH);
    localparam int unsigned ADDR_W = addr_w(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty, full;
    logic              wr_acc, rd_acc;
    logic [WIDTH-1:0]  mem_rdata;

    // Flags come only from registered count, never from the strobes.
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = ADDR_W'(ptr_inc(word_t'(wr_ptr_q), word_t'(DEPTH)));
        end
        if (rd_acc) begin
            rd_ptr_d = ADDR_W'(ptr_inc(word_t'(rd_ptr_q), word_t'(DEPTH)));
        end
        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem_dp #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FWFT   (FWFT)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        bus.rd_data = mem_rdata;
        // A fall-through head shows zero rather than stale storage when empty.
        if (FWFT != 0 && empty) begin
            bus.rd_data = '0;
        end
    end

    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_full  = (count_q >= bus.afull_thresh);
    assign bus.almost_empty = (count_q <= bus.aempty_thresh);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (bus.wr_en & full);
            underflow_q <= underflow_q | (bus.rd_en & empty);
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: DEPTH=6 registered-read table, DEPTH=8 thresholds,
// DEPTH=4 FWFT sequence and asynchronous mid-stream reset.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    param_sync_fifo_if #(.WIDTH(8), .DEPTH(6)) d6_if ();
    param_sync_fifo_if #(.WIDTH(8), .DEPTH(8)) d8_if ();
    param_sync_fifo_if #(.WIDTH(8), .DEPTH(4)) fw_if ();

    param_sync_fifo #(.WIDTH(8), .DEPTH(6), .FWFT(0)) u_d6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (d6_if)
    );

    param_sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0)) u_d8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (d8_if)
    );

    param_sync_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fw_if)
    );

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic [7:0] rdat;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic w, input int wd, input logic r,
                                input int rdat, input int c);
        vec_t v;
        v.wr   = w;
        v.wd   = 8'(wd);
        v.rd   = r;
        v.rdat = 8'(rdat);
        v.cnt  = 3'(c);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fw_step(input logic w, input int wd, input logic r,
                           input int exp_rd, input int exp_cnt, input string name);
        fw_if.wr_en   = w;
        fw_if.wr_data = 8'(wd);
        fw_if.rd_en   = r;
        @(posedge clk);
        #1;
        fw_if.wr_en = 1'b0;
        fw_if.rd_en = 1'b0;
        chk({name, " rd_data"}, 32'(fw_if.rd_data), exp_rd);
        chk({name, " count"}, 32'(fw_if.count), exp_cnt);
        chk({name, " empty"}, 32'(fw_if.empty), (exp_cnt == 0) ? 1 : 0);
    endtask

    logic [8:0] af_tab;
    logic [8:0] ae_tab;

    initial begin
        d6_if.wr_en = 1'b0; d6_if.wr_data = '0; d6_if.rd_en = 1'b0;
        d6_if.afull_thresh = 3'd5; d6_if.aempty_thresh = 3'd1;
        d8_if.wr_en = 1'b0; d8_if.wr_data = '0; d8_if.rd_en = 1'b0;
        d8_if.afull_thresh = 4'd5; d8_if.aempty_thresh = 4'd1;
        fw_if.wr_en = 1'b0; fw_if.wr_data = '0; fw_if.rd_en = 1'b0;
        fw_if.afull_thresh = 3'd0; fw_if.aempty_thresh = 3'd0;
        af_tab = 9'b111100000;
        ae_tab = 9'b000000011;

        // Fill, overflow attempt, drain, underflow attempt.
        for (int i = 0; i < 6; i++) add(1'b1, i + 1, 1'b0, 0, i + 1);
        add(1'b1, 'hFF, 1'b0, 0, 6);
        for (int i = 0; i < 6; i++) add(1'b0, 0, 1'b1, i + 1, 5 - i);
        add(1'b0, 0, 1'b1, 6, 0);
        // Simultaneous at empty, then at count 1.
        add(1'b1, 'h10, 1'b1, 6, 1);
        add(1'b1, 'h11, 1'b1, 'h10, 1);
        add(1'b1, 'h12, 1'b0, 'h10, 2);
        add(1'b1, 'h13, 1'b0, 'h10, 3);
        // Ten simultaneous cycles at count 3.
        for (int k = 0; k < 10; k++) begin
            add(1'b1, 'h20 + k, 1'b1, (k < 3) ? ('h11 + k) : ('h20 + k - 3), 3);
        end
        add(1'b1, 'h30, 1'b0, 'h26, 4);
        add(1'b1, 'h31, 1'b0, 'h26, 5);
        add(1'b1, 'h32, 1'b0, 'h26, 6);
        // Simultaneous at full: read succeeds, 0xEE is dropped.
        add(1'b1, 'hEE, 1'b1, 'h27, 5);
        add(1'b0, 0, 1'b1, 'h28, 4);
        add(1'b0, 0, 1'b1, 'h29, 3);
        add(1'b0, 0, 1'b1, 'h30, 2);
        add(1'b0, 0, 1'b1, 'h31, 1);
        add(1'b0, 0, 1'b1, 'h32, 0);
        // Twenty write/read pairs carry both pointers around several times.
        for (int k = 0; k < 20; k++) begin
            add(1'b1, 'h40 + k, 1'b0, (k == 0) ? 'h32 : ('h40 + k - 1), 1);
            add(1'b0, 0, 1'b1, 'h40 + k, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(d6_if.count), 0);
        chk("reset empty", 32'(d6_if.empty), 1);
        chk("reset full", 32'(d6_if.full), 0);
        chk("reset rd_data", 32'(d6_if.rd_data), 0);
        chk("reset almost_empty", 32'(d6_if.almost_empty), 1);
        chk("reset almost_full thr5", 32'(d6_if.almost_full), 0);
        chk("reset almost_full thr0", 32'(fw_if.almost_full), 1);
        chk("reset fwft rd_data", 32'(fw_if.rd_data), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("reset overflow", 32'(d6_if.overflow), 0);
        chk("reset underflow", 32'(d6_if.underflow), 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            d6_if.wr_en   = vecs[i].wr;
            d6_if.wr_data = vecs[i].wd;
            d6_if.rd_en   = vecs[i].rd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d count", i), 32'(d6_if.count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d rd_data", i), 32'(d6_if.rd_data), 32'(vecs[i].rdat));
            chk($sformatf("vec%0d empty", i), 32'(d6_if.empty), (vecs[i].cnt == 3'd0) ? 1 : 0);
            chk($sformatf("vec%0d full", i), 32'(d6_if.full), (vecs[i].cnt == 3'd6) ? 1 : 0);
        end
        d6_if.wr_en = 1'b0;
        d6_if.rd_en = 1'b0;

        // Threshold sweep over counts 0..8 on the DEPTH=8 instance.
        for (int c = 0; c <= 8; c++) begin
            chk($sformatf("thr count%0d", c), 32'(d8_if.count), c);
            chk($sformatf("thr almost_full@%0d", c), 32'(d8_if.almost_full), 32'(af_tab[c]));
            chk($sformatf("thr almost_empty@%0d", c), 32'(d8_if.almost_empty), 32'(ae_tab[c]));
            if (c < 8) begin
                d8_if.wr_en   = 1'b1;
                d8_if.wr_data = 8'(c);
                @(posedge clk);
                #1;
                d8_if.wr_en = 1'b0;
            end
        end
        chk("thr full@8", 32'(d8_if.full), 1);

        // Fall-through read mode.
        fw_step(1'b1, 'hA5, 1'b0, 'hA5, 1, "fw write A5");
        fw_step(1'b0, 0, 1'b0, 'hA5, 1, "fw hold A5");
        fw_step(1'b0, 0, 1'b1, 0, 0, "fw pop A5");
        fw_step(1'b1, 'hB1, 1'b0, 'hB1, 1, "fw write B1");
        fw_step(1'b1, 'hB2, 1'b0, 'hB1, 2, "fw write B2");
        fw_step(1'b0, 0, 1'b1, 'hB2, 1, "fw pop B1");
        fw_step(1'b1, 'hB3, 1'b1, 'hB3, 1, "fw rw at count1");
        fw_step(1'b0, 0, 1'b1, 0, 0, "fw pop B3");

`ifdef FIFO_ERR_FLAGS_EN
        chk("sticky overflow", 32'(d6_if.overflow), 1);
        chk("sticky underflow", 32'(d6_if.underflow), 1);
`endif

        // Asynchronous reset between edges at count 4.
        for (int k = 0; k < 4; k++) begin
            d6_if.wr_en   = 1'b1;
            d6_if.wr_data = 8'('h50 + k);
            @(posedge clk);
            #1;
        end
        d6_if.wr_en = 1'b0;
        chk("pre-reset count", 32'(d6_if.count), 4);
        chk("pre-reset rd_data", 32'(d6_if.rd_data), 'h53);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset count", 32'(d6_if.count), 0);
        chk("async reset empty", 32'(d6_if.empty), 1);
        chk("async reset rd_data", 32'(d6_if.rd_data), 0);
        chk("async reset d8 count", 32'(d8_if.count), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("async reset overflow", 32'(d6_if.overflow), 0);
        chk("async reset underflow", 32'(d6_if.underflow), 0);
`endif
        #2;
        rst_n = 1'b1;
        d6_if.wr_en   = 1'b1;
        d6_if.wr_data = 8'h77;
        @(posedge clk);
        #1;
        d6_if.wr_en = 1'b0;
        d6_if.rd_en = 1'b1;
        @(posedge clk);
        #1;
        d6_if.rd_en = 1'b0;
        chk("post-reset rd_data", 32'(d6_if.rd_data), 'h77);
        chk("post-reset count", 32'(d6_if.count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
